// File: rtl/softex_cast_out_packer.sv
// Packs PACK narrow cast-integer beats into one DATA_WIDTH word, with flush of partial words
// and a combinational bypass when packing is disabled.
module softex_cast_out_packer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FP_WIDTH   = 16,
  parameter int unsigned INT_WIDTH  = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clear_i,
  input  logic                    enable_i,
  input  logic                    flush_i,
  input  logic                    stream_i_valid_i,
  output logic                    stream_i_ready_o,
  input  logic [DATA_WIDTH-1:0]   stream_i_data_i,
  input  logic [DATA_WIDTH/8-1:0] stream_i_strb_i,
  output logic                    stream_o_valid_o,
  input  logic                    stream_o_ready_i,
  output logic [DATA_WIDTH-1:0]   stream_o_data_o,
  output logic [DATA_WIDTH/8-1:0] stream_o_strb_o,
  output logic                    idle_o
);

  localparam int unsigned PACK   = FP_WIDTH / INT_WIDTH;
  localparam int unsigned W_IN   = DATA_WIDTH * INT_WIDTH / FP_WIDTH;
  localparam int unsigned S_IN   = W_IN / 8;
  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned CNT_W  = (PACK > 1) ? $clog2(PACK) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(PACK - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_acc;
  logic [DATA_WIDTH-1:0] buf_data_q, buf_data_d, buf_data_m;
  logic [STRB_W-1:0]     buf_strb_q, buf_strb_d, buf_strb_m;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [STRB_W-1:0]     out_strb_q, out_strb_d;
  logic                  out_valid_q, out_valid_d;
  logic                  flush_pend_q, flush_pend_d;

  logic out_free, pack_ready, accept, complete, flush_req, flush_load, load;

  assign out_free   = !out_valid_q || stream_o_ready_i;
  assign pack_ready = out_free && !flush_pend_q;
  assign accept     = stream_i_valid_i && pack_ready;
  assign complete   = accept && (cnt_q == LAST_SLOT);
  assign flush_req  = flush_i || flush_pend_q;

  // Fill buffer as it looks after this cycle's accept; both the completing load and a
  // flush take their word from here so a same-cycle beat is never lost.
  always_comb begin
    buf_data_m = buf_data_q;
    buf_strb_m = buf_strb_q;
    for (int i = 0; i < int'(PACK); i++) begin
      if (accept && (cnt_q == CNT_W'(i))) begin
        buf_data_m[i*W_IN +: W_IN] = stream_i_data_i[W_IN-1:0];
        buf_strb_m[i*S_IN +: S_IN] = stream_i_strb_i[S_IN-1:0];
      end
    end
  end

  assign cnt_acc    = complete ? '0 : (accept ? cnt_q + CNT_W'(1) : cnt_q);
  assign flush_load = flush_req && out_free && !complete && (cnt_acc != '0);
  assign load       = complete || flush_load;

  always_comb begin
    cnt_d        = cnt_acc;
    buf_data_d   = buf_data_m;
    buf_strb_d   = buf_strb_m;
    out_data_d   = out_data_q;
    out_strb_d   = out_strb_q;
    out_valid_d  = out_valid_q && !stream_o_ready_i;
    // A flush that cannot run yet is remembered; it resolves on the first free cycle.
    flush_pend_d = flush_req && !out_free;
    if (load) begin
      out_data_d  = buf_data_m;
      out_strb_d  = buf_strb_m;
      out_valid_d = 1'b1;
      cnt_d       = '0;
      buf_data_d  = '0;
      buf_strb_d  = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      buf_data_q   <= '0;
      buf_strb_q   <= '0;
      out_data_q   <= '0;
      out_strb_q   <= '0;
      out_valid_q  <= 1'b0;
      flush_pend_q <= 1'b0;
    end else if (clear_i) begin
      cnt_q        <= '0;
      buf_data_q   <= '0;
      buf_strb_q   <= '0;
      out_data_q   <= '0;
      out_strb_q   <= '0;
      out_valid_q  <= 1'b0;
      flush_pend_q <= 1'b0;
    end else if (enable_i) begin
      cnt_q        <= cnt_d;
      buf_data_q   <= buf_data_d;
      buf_strb_q   <= buf_strb_d;
      out_data_q   <= out_data_d;
      out_strb_q   <= out_strb_d;
      out_valid_q  <= out_valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign stream_i_ready_o = enable_i ? pack_ready  : stream_o_ready_i;
  assign stream_o_valid_o = enable_i ? out_valid_q : stream_i_valid_i;
  assign stream_o_data_o  = enable_i ? out_data_q  : stream_i_data_i;
  assign stream_o_strb_o  = enable_i ? out_strb_q  : stream_i_strb_i;
  assign idle_o           = (cnt_q == '0) && !out_valid_q && !flush_pend_q;

endmodule

// File: doc/softex_cast_out_packer.md
SOFTEX_CAST_OUT_PACKER -- requirements
Module: softex_cast_out_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default DATA_W: stream bus width in bits.
REQ-002 SHALL have parameter FP_WIDTH, default fpnew_pkg::fp_width(FPFORMAT_IN): upstream element width in bits.
REQ-003 SHALL have parameter INT_WIDTH, default INT_W: cast integer width in bits; FP_WIDTH/INT_WIDTH (PACK) is a power of two >= 1.
REQ-004 SHALL derive W_IN = DATA_WIDTH*INT_WIDTH/FP_WIDTH, the useful bits per input beat.
REQ-005 SHALL have port clk_i  input  1  clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port clear_i  input  1  synchronous clear, same effect as reset.
REQ-008 SHALL have port enable_i  input  1  1 = pack, 0 = combinational bypass.
REQ-009 SHALL have port flush_i  input  1  single-cycle pulse that emits a partial word.
REQ-010 SHALL have port stream_i  hwpe_stream_intf_stream.sink  DATA_WIDTH  cast integer beats.
REQ-011 SHALL have port stream_o  hwpe_stream_intf_stream.source  DATA_WIDTH  packed words.
REQ-012 SHALL have port idle_o  output  1  high when no slot is filled, no word is pending and no flush is pending.

Function
REQ-013 Input beats SHALL carry data in stream_i.data[W_IN-1:0] and strb[W_IN/8-1:0]; upper bits SHALL be ignored.
REQ-014 Slot counter cnt_q (0..PACK-1): an accepted beat SHALL write fill-buffer slot cnt_q, data [cnt_q*W_IN +: W_IN] and matching strb bits.
REQ-015 Accept SHALL occur when stream_i.valid && stream_i.ready; stream_i.ready = !out_valid_q || stream_o.ready while enable_i=1.
REQ-016 Accept at cnt_q=PACK-1 SHALL copy the completed buffer plus the new beat into the output register, set out_valid_q, set cnt_q to 0 and zero the fill strb.
REQ-017 Latency: stream_o.valid SHALL rise in the cycle after the completing accept.
REQ-018 stream_o.data/strb SHALL be driven from the output register; out_valid_q SHALL clear on stream_o.ready unless a new word loads in the same cycle.
REQ-019 Output strb for slots that were never filled SHALL be 0; data in those slots SHALL be 0.
REQ-020 flush_i with cnt_q>0 (after the same-cycle accept, if any) and the output register free or draining SHALL move the partial buffer to the output register and reset cnt_q to 0.
REQ-021 flush_i while the output register is occupied and stream_o.ready=0 SHALL set flush_pend_q; the flush SHALL execute on the first cycle the register frees; stream_i.ready SHALL be 0 while flush_pend_q=1.
REQ-022 flush_i with cnt_q=0 and no same-cycle accept SHALL be a no-op; no empty word SHALL be emitted.
REQ-023 A same-cycle completing accept and flush_i SHALL emit exactly one full word with no extra empty word.
REQ-024 With enable_i=0: stream_o SHALL mirror stream_i (data, strb, valid), stream_i.ready = stream_o.ready, and internal state SHALL be held.
REQ-025 enable_i SHALL only be changed while idle_o=1; behaviour is otherwise undefined.
REQ-026 idle_o SHALL equal (cnt_q==0) && !out_valid_q && !flush_pend_q.

Reset
REQ-027 rst_i or clear_i SHALL set cnt_q=0, out_valid_q=0, flush_pend_q=0, and buffer and output data/strb to 0, giving stream_o.valid=0 and idle_o=1.
REQ-028 Reset mid-operation SHALL discard partial and pending words with no output beat.

Verification (DATA_WIDTH=32, FP_WIDTH=16, INT_WIDTH=8, so W_IN=16, PACK=2)
REQ-029 Beats 0x____1234 then 0x____5678, strb 0b0011 each, ready=1 -> one cycle after beat 2: data 0x56781234, strb 0xF, single valid cycle.
REQ-030 Beat 0x____00AB, then flush_i -> data 0x000000AB, strb 0x3; idle_o=1 afterwards.
REQ-031 Full word held with stream_o.ready=0, then flush_i with cnt_q=1 -> stream_i.ready=0, flush_pend_q=1; on release the held word goes first, then the partial word.
REQ-032 Completing beat and flush_i in the same cycle -> exactly one word, strb 0xF.
REQ-033 enable_i=0, input 0xDEADBEEF, strb 0xF -> identical on stream_o in the same cycle; cnt_q unchanged.
REQ-034 rst_i asserted with cnt_q=1 -> asynchronous clear; after release, next two beats form a clean word.
